// File: rtl/mat_pkg.sv
// Shared constants for the matrix storage subsystem: storage geometry,
// channel identifiers and arbitration mode selectors.
package mat_pkg;

    localparam int MAT_ADDR_W = 9;
    localparam int MAT_DATA_W = 32;

    localparam int CH_INPUT = 0;
    localparam int CH_CALC  = 1;
    localparam int CH_DISP  = 2;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority one-hot encoder: the first set bit of req at or after ptr
// (wrapping) wins. A ptr of zero gives plain lowest-index priority.
module rr_pick #(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the channels in rotated order and flag the first requester.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s      = PTR_W'((int'(ptr) + i) % NUM_CH);
            gnt[idx_s] = req[idx_s] & ~found_s;
            found_s    = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// N-channel request/grant arbiter for the single-port matrix RAM: registered
// one-hot grants, burst locking, a starvation cap and per-channel read tracking.
module storage_arbiter
    import mat_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = MAT_ADDR_W,
    parameter int DATA_W    = MAT_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int MAX_HOLD  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH-1:0]        i_lock,
    input  logic [NUM_CH-1:0]        i_we,
    input  logic [NUM_CH*ADDR_W-1:0] i_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_wdata,
    output logic [NUM_CH-1:0]        o_gnt,
    output logic [NUM_CH-1:0]        o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic                     o_mem_we,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic                     o_busy
);

    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [NUM_CH-1:0] gnt_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [HOLD_W-1:0] hold_r;
    logic [RD_LAT-1:0] pipe_v_r;
    logic [NUM_CH-1:0] pipe_ch_r [RD_LAT];

    logic [NUM_CH-1:0] rd_ch_s;
    logic              owner_lock_s;
    logic              others_s;
    logic              cap_hit_s;
    logic              keep_s;
    logic [NUM_CH-1:0] pick_req_s;
    logic [PTR_W-1:0]  pick_ptr_s;
    logic [NUM_CH-1:0] pick_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic [NUM_CH-1:0] gnt_nxt_s;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [HOLD_W-1:0] hold_nxt_s;

    assign rd_ch_s      = gnt_r & i_req & ~i_we;
    assign owner_lock_s = |(gnt_r & i_req & i_lock);
    assign others_s     = |(i_req & ~gnt_r);
    assign cap_hit_s    = (PRIO_MODE == PRIO_RR) && (hold_r >= HOLD_W'(MAX_HOLD)) && others_s;
    assign keep_s       = owner_lock_s && !cap_hit_s;
    // A capped owner is masked out so it sits out at least one cycle.
    assign pick_req_s   = cap_hit_s ? (i_req & ~gnt_r) : i_req;
    assign pick_ptr_s   = (PRIO_MODE == PRIO_FIXED) ? '0 : ptr_r;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req (pick_req_s),
        .ptr (pick_ptr_s),
        .gnt (pick_s)
    );

    // Next grant, round-robin pointer and hold counter.
    always_comb begin
        gnt_nxt_s  = pick_s;
        ptr_nxt_s  = ptr_r;
        hold_nxt_s = '0;
        win_idx_s  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            win_idx_s = win_idx_s | ({PTR_W{pick_s[k]}} & PTR_W'(k));
        end
        if (keep_s) begin
            gnt_nxt_s  = gnt_r;
            hold_nxt_s = (hold_r == HOLD_W'(MAX_HOLD)) ? hold_r : hold_r + 1'b1;
        end else if (|pick_s) begin
            ptr_nxt_s = (win_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : win_idx_s + 1'b1;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Grant state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= '0;
            ptr_r  <= '0;
            hold_r <= '0;
        end else begin
            gnt_r  <= gnt_nxt_s;
            ptr_r  <= ptr_nxt_s;
            hold_r <= hold_nxt_s;
        end
    end

    // Read-tracking pipe; its tail lines up with the storage read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_ch_r[i] <= '0;
            end
        end else begin
            pipe_v_r[0]  <= |rd_ch_s;
            pipe_ch_r[0] <= rd_ch_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_r[i]  <= pipe_v_r[i-1];
                pipe_ch_r[i] <= pipe_ch_r[i-1];
            end
        end
    end

    // Storage port mux; the grant is one-hot so OR-ing the masked lanes selects it.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_mem_addr  = o_mem_addr  | ({ADDR_W{gnt_r[k]}} & i_addr[k*ADDR_W +: ADDR_W]);
            o_mem_wdata = o_mem_wdata | ({DATA_W{gnt_r[k]}} & i_wdata[k*DATA_W +: DATA_W]);
            o_mem_we    = o_mem_we    | (gnt_r[k] & i_req[k] & i_we[k]);
        end
    end

    assign o_gnt    = gnt_r;
    assign o_rvalid = {NUM_CH{pipe_v_r[RD_LAT-1]}} & pipe_ch_r[RD_LAT-1];
    assign o_rdata  = i_mem_rdata;
    assign o_busy   = (|gnt_r) | (|pipe_v_r);

endmodule

// File: tb/tb_storage_arbiter.sv
// Scoreboard bench for storage_arbiter: a round-robin instance backed by a
// behavioural RAM and a fixed-priority instance driven by the same stimulus.
module tb_storage_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 9;
    localparam int DW  = 32;

    typedef struct packed {
        logic [NCH-1:0] ch;
        logic [DW-1:0]  data;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req, lock, we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;

    logic [NCH-1:0] gnt, rvalid;
    logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]  mem_addr;
    logic           mem_we, busy;

    logic [NCH-1:0] fx_gnt, fx_rvalid;
    logic [DW-1:0]  fx_rdata, fx_wdata;
    logic [AW-1:0]  fx_addr;
    logic           fx_we, fx_busy;

    logic [DW-1:0] mem [512];

    logic [NCH-1:0] gnt_q [$];
    logic [NCH-1:0] fx_q  [$];
    rd_t            rd_q  [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    storage_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_MODE(0), .MAX_HOLD(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid),
        .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    storage_arbiter #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_MODE(1), .MAX_HOLD(16)
    ) dut_fx (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_gnt(fx_gnt), .o_rvalid(fx_rvalid),
        .o_rdata(fx_rdata), .o_mem_addr(fx_addr), .o_mem_wdata(fx_wdata),
        .o_mem_we(fx_we), .i_mem_rdata(32'h0000_0000), .o_busy(fx_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with one cycle of read latency.
    initial begin
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[5]    = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            a = mem_addr;
            w = mem_we;
            d = mem_wdata;
            @(posedge clk);
            if (w) mem[a] = d;
            mem_rdata = mem[a];
        end
    end

    // Monitor: pops expectations whenever the DUTs present grants or read data.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (gnt_q.size() > 0) check("gnt", 64'(gnt), 64'(gnt_q.pop_front()));
                if (fx_q.size() > 0)  check("fx_gnt", 64'(fx_gnt), 64'(fx_q.pop_front()));
                if (rvalid != '0) begin
                    if (rd_q.size() == 0) begin
                        check("rvalid_unexpected", 64'(rvalid), 64'(0));
                    end else begin
                        e = rd_q.pop_front();
                        check("rvalid", 64'(rvalid), 64'(e.ch));
                        check("rdata", 64'(rdata), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic set_ch(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
    endtask

    // Drive req for one cycle and queue the grants expected in that cycle.
    task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] eg, input logic [NCH-1:0] ef);
        req = r;
        gnt_q.push_back(eg);
        fx_q.push_back(ef);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        logic acc;
        logic [NCH-1:0] eg, ef;

        // Reset state
        do_reset();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_fx_gnt", 64'(fx_gnt), 64'(0));
        check("rst_fx_busy", 64'(fx_busy), 64'(0));
        check("rst_fx_we", 64'(fx_we), 64'(0));
        check("rst_fx_rvalid", 64'(fx_rvalid), 64'(0));
        check("rst_fx_addr", 64'(fx_addr), 64'(0));
        check("rst_fx_wdata", 64'(fx_wdata), 64'(0));
        check("rst_fx_rdata", 64'(fx_rdata), 64'(0));

        // Round-robin rotation, all three writing, no lock
        we = 3'b111;
        set_ch(0, 9'h100, 32'hA0A0_0000);
        set_ch(1, 9'h101, 32'hA1A1_1111);
        set_ch(2, 9'h102, 32'hA2A2_2222);
        step(3'b111, 3'b000, 3'b000);
        step(3'b111, 3'b001, 3'b001);
        step(3'b111, 3'b010, 3'b001);
        step(3'b111, 3'b100, 3'b001);
        step(3'b000, 3'b001, 3'b001);
        step(3'b000, 3'b000, 3'b000);
        check("rr_mem0", 64'(mem[9'h100]), 64'(32'hA0A0_0000));
        check("rr_mem1", 64'(mem[9'h101]), 64'(32'hA1A1_1111));
        check("rr_mem2", 64'(mem[9'h102]), 64'(32'hA2A2_2222));

        // Single read on ch1: grant at t+1, data at t+2
        do_reset();
        we = 3'b000;
        set_ch(1, 9'h005, 32'h0);
        rd_q.push_back('{ch: 3'b010, data: 32'hDEAD_BEEF});
        step(3'b010, 3'b000, 3'b000);
        step(3'b010, 3'b010, 3'b010);
        check("rd_busy", 64'(busy), 64'(1));
        step(3'b000, 3'b010, 3'b010);
        step(3'b000, 3'b000, 3'b000);
        check("rd_idle_busy", 64'(busy), 64'(0));

        // Locked burst on ch0 with ch2 waiting: initial grant plus 16 locked re-grants, then ch2 once
        do_reset();
        idx  = 0;
        lock = 3'b001;
        we   = 3'b101;
        set_ch(2, 9'h1F0, 32'h2222_2222);
        for (int c = 0; c < 45; c++) begin
            req = (idx < 40) ? 3'b101 : 3'b000;
            set_ch(0, 9'(9'h040 + idx), 32'hC0DE_0000 + 32'(idx));
            if (c == 0)                eg = 3'b000;
            else if (c == 18 || c == 36) eg = 3'b100;
            else if (c <= 43)          eg = 3'b001;
            else                       eg = 3'b000;
            ef = (c == 0 || c == 44) ? 3'b000 : 3'b001;
            gnt_q.push_back(eg);
            fx_q.push_back(ef);
            @(negedge clk);
            acc = gnt[0] & req[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("burst_words", 64'(idx), 64'(40));
        for (int i = 0; i < 40; i++) begin
            check("burst_mem", 64'(mem[9'h040 + 9'(i)]), 64'(32'hC0DE_0000 + 32'(i)));
        end
        check("burst_ch2_mem", 64'(mem[9'h1F0]), 64'(32'h2222_2222));

        // ch2 then ch0: fixed priority starves ch2, round-robin alternates
        do_reset();
        we = 3'b111;
        step(3'b100, 3'b000, 3'b000);
        step(3'b101, 3'b100, 3'b100);
        step(3'b101, 3'b001, 3'b001);
        step(3'b101, 3'b100, 3'b001);
        step(3'b101, 3'b001, 3'b001);
        step(3'b000, 3'b100, 3'b001);
        step(3'b000, 3'b000, 3'b000);

        // Reset pulse while a ch1 read is being issued
        do_reset();
        we = 3'b000;
        set_ch(1, 9'h007, 32'h0);
        step(3'b010, 3'b000, 3'b000);
        @(negedge clk);
        check("rstpulse_gnt_before", 64'(gnt), 64'(3'b010));
        #1;
        rst_n = 1'b0;
        req   = '0;
        #2;
        rst_n = 1'b1;
        check("rstpulse_gnt_after", 64'(gnt), 64'(0));
        check("rstpulse_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstpulse_rvalid", 64'(rvalid), 64'(0));
        end

        @(posedge clk);
        #1;
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("gnt_q_drained", 64'(gnt_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
